// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite command master: response code and FSM encoding.
package axil_pkg;

  // AXI response code for a successful transfer; every other value counts as an error.
  localparam int unsigned RESP_OKAY = 0;

  // Transaction sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,  // waiting for a queued command
    ST_WR   = 3'd1,  // AW and/or W still being offered
    ST_WR_B = 3'd2,  // waiting for the write response
    ST_RD   = 3'd3,  // AR being offered
    ST_RD_R = 3'd4,  // waiting for read data
    ST_RSP  = 3'd5   // result presented on the response stream
  } state_e;

endpackage

// File: rtl/axil_cmd_fifo.sv
// Two-entry command queue in front of the AXI sequencer.
// push_ready_o comes straight from a flop, so a push offered while the queue is
// full is refused even if an entry leaves in that same cycle.
module axil_cmd_fifo #(
  parameter int WIDTH = 45
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid_i,
  output logic             push_ready_o,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             not_empty_o,
  output logic [WIDTH-1:0] pop_data_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       cnt_q;
  logic [1:0]       cnt_d;
  logic             ready_q;
  logic             push;
  logic             pop;

  assign push         = push_valid_i & ready_q;
  assign pop          = pop_i & (cnt_q != 2'd0);
  assign not_empty_o  = (cnt_q != 2'd0);
  assign push_ready_o = ready_q;
  assign pop_data_o   = mem_q[rd_ptr_q];

  // Occupancy after this cycle's push and pop.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!push && pop) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  // Pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      ready_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      cnt_q   <= cnt_d;
      ready_q <= (cnt_d != 2'd2);
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/axil_cmd_master.sv
// AXI4-Lite master: turns queued commands into single AXI-Lite reads or writes,
// one outstanding at a time, and reports each result on a response stream.
//
// Handshakes: every channel transfers on a rising edge where valid and ready are
// both high. A valid, once raised, stays high with its payload unchanged until
// that edge; ready may rise and fall freely. Outputs here only react to the
// handshake on the following cycle.
module axil_cmd_master import axil_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    s3_axi_aclk,
  input  logic                    s3_axi_aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [RESP_WIDTH-1:0]   rsp_resp,
  output logic [ADDR_WIDTH-1:0]   m3_axi_awaddr,
  output logic                    m3_axi_awvalid,
  input  logic                    m3_axi_awready,
  output logic [DATA_WIDTH-1:0]   m3_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m3_axi_wstrb,
  output logic                    m3_axi_wvalid,
  input  logic                    m3_axi_wready,
  input  logic [RESP_WIDTH-1:0]   m3_axi_bresp,
  input  logic                    m3_axi_bvalid,
  output logic                    m3_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m3_axi_araddr,
  output logic                    m3_axi_arvalid,
  input  logic                    m3_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m3_axi_rdata,
  input  logic [RESP_WIDTH-1:0]   m3_axi_rresp,
  input  logic                    m3_axi_rvalid,
  output logic                    m3_axi_rready,
  output logic [CNT_WIDTH-1:0]    wr_done_cnt,
  output logic [CNT_WIDTH-1:0]    rd_done_cnt,
  output logic [CNT_WIDTH-1:0]    err_cnt,
  output logic [2:0]              dbg_state
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int FIFO_WIDTH = 1 + ADDR_WIDTH + DATA_WIDTH + STRB_WIDTH;

  // Queue interface
  logic                  fifo_pop;
  logic                  fifo_not_empty;
  logic [FIFO_WIDTH-1:0] fifo_dout;
  logic                  f_write;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic [DATA_WIDTH-1:0] f_wdata;
  logic [STRB_WIDTH-1:0] f_wstrb;

  // Registered state and outputs
  state_e                state_q, state_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [RESP_WIDTH-1:0] rsp_resp_q, rsp_resp_d;
  logic [CNT_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic                  aw_fin;
  logic                  w_fin;

  axil_cmd_fifo #(
    .WIDTH(FIFO_WIDTH)
  ) u_fifo (
    .clk         (s3_axi_aclk),
    .rst_n       (s3_axi_aresetn),
    .push_valid_i(cmd_valid),
    .push_ready_o(cmd_ready),
    .push_data_i ({cmd_write, cmd_addr, cmd_wdata, cmd_wstrb}),
    .pop_i       (fifo_pop),
    .not_empty_o (fifo_not_empty),
    .pop_data_o  (fifo_dout)
  );

  assign {f_write, f_addr, f_wdata, f_wstrb} = fifo_dout;

  // Sequencer next state: launch, track AW/W completion, capture responses, count results.
  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    err_cnt_d   = err_cnt_q;
    fifo_pop    = 1'b0;
    aw_fin      = !awvalid_q || m3_axi_awready;
    w_fin       = !wvalid_q || m3_axi_wready;

    case (state_q)
      ST_IDLE: begin
        if (fifo_not_empty) begin
          fifo_pop = 1'b1;
          addr_d   = f_addr;
          wdata_d  = f_wdata;
          wstrb_d  = f_wstrb;
          if (f_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD;
          end
        end
      end
      ST_WR: begin
        // AW and W retire independently; the response phase starts once both have.
        if (awvalid_q && m3_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m3_axi_wready)   wvalid_d  = 1'b0;
        if (aw_fin && w_fin) begin
          bready_d = 1'b1;
          state_d  = ST_WR_B;
        end
      end
      ST_WR_B: begin
        if (m3_axi_bvalid) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m3_axi_bresp;
          state_d     = ST_RSP;
        end
      end
      ST_RD: begin
        if (m3_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_R;
        end
      end
      ST_RD_R: begin
        if (m3_axi_rvalid) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = m3_axi_rdata;
          rsp_resp_d  = m3_axi_rresp;
          state_d     = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (rsp_write_q) wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
          else             rd_cnt_d = rd_cnt_q + CNT_WIDTH'(1);
          if ((rsp_resp_q != RESP_WIDTH'(RESP_OKAY)) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge s3_axi_aclk or negedge s3_axi_aresetn) begin
    if (!s3_axi_aresetn) begin
      state_q     <= ST_IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign m3_axi_awaddr  = addr_q;
  assign m3_axi_awvalid = awvalid_q;
  assign m3_axi_wdata   = wdata_q;
  assign m3_axi_wstrb   = wstrb_q;
  assign m3_axi_wvalid  = wvalid_q;
  assign m3_axi_bready  = bready_q;
  assign m3_axi_araddr  = addr_q;
  assign m3_axi_arvalid = arvalid_q;
  assign m3_axi_rready  = rready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_write      = rsp_write_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_resp       = rsp_resp_q;
  assign wr_done_cnt    = wr_cnt_q;
  assign rd_done_cnt    = rd_cnt_q;
  assign err_cnt        = err_cnt_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master with a small AXI4-Lite slave model.
module tb_axil_cmd_master;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int RW = 3;
  localparam int CW = 16;
  localparam int SW = DW / 8;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [RW-1:0] rsp_resp;
  logic [AW-1:0] m3_axi_awaddr, m3_axi_araddr;
  logic          m3_axi_awvalid, m3_axi_awready;
  logic [DW-1:0] m3_axi_wdata, m3_axi_rdata;
  logic [SW-1:0] m3_axi_wstrb;
  logic          m3_axi_wvalid, m3_axi_wready;
  logic [RW-1:0] m3_axi_bresp, m3_axi_rresp;
  logic          m3_axi_bvalid, m3_axi_bready;
  logic          m3_axi_arvalid, m3_axi_arready;
  logic          m3_axi_rvalid, m3_axi_rready;
  logic [CW-1:0] wr_done_cnt, rd_done_cnt, err_cnt;
  logic [2:0]    dbg_state;

  // Bookkeeping
  int total = 0;
  int bad = 0;

  // Slave configuration and observation
  int            aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [RW-1:0] bresp_cfg = '0;
  logic [RW-1:0] rresp_cfg = '0;
  int            aw_beats = 0, w_beats = 0, ar_beats = 0;
  logic [DW-1:0] mem [64];

  axil_cmd_master #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW), .CNT_WIDTH(CW)
  ) dut (
    .s3_axi_aclk   (clk),
    .s3_axi_aresetn(rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_wstrb     (cmd_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_write     (rsp_write),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .m3_axi_awaddr (m3_axi_awaddr),
    .m3_axi_awvalid(m3_axi_awvalid),
    .m3_axi_awready(m3_axi_awready),
    .m3_axi_wdata  (m3_axi_wdata),
    .m3_axi_wstrb  (m3_axi_wstrb),
    .m3_axi_wvalid (m3_axi_wvalid),
    .m3_axi_wready (m3_axi_wready),
    .m3_axi_bresp  (m3_axi_bresp),
    .m3_axi_bvalid (m3_axi_bvalid),
    .m3_axi_bready (m3_axi_bready),
    .m3_axi_araddr (m3_axi_araddr),
    .m3_axi_arvalid(m3_axi_arvalid),
    .m3_axi_arready(m3_axi_arready),
    .m3_axi_rdata  (m3_axi_rdata),
    .m3_axi_rresp  (m3_axi_rresp),
    .m3_axi_rvalid (m3_axi_rvalid),
    .m3_axi_rready (m3_axi_rready),
    .wr_done_cnt   (wr_done_cnt),
    .rd_done_cnt   (rd_done_cnt),
    .err_cnt       (err_cnt),
    .dbg_state     (dbg_state)
  );

  // Slave model: handshakes judged at negedge, responses updated just after posedge.
  initial begin : slave
    logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic          aw_got, w_got, ar_got;
    logic [AW-1:0] s_awaddr, s_araddr;
    logic [DW-1:0] s_wdata;
    logic [SW-1:0] s_wstrb;
    int            aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    m3_axi_awready = 1'b0; m3_axi_wready = 1'b0; m3_axi_arready = 1'b0;
    m3_axi_bvalid = 1'b0;  m3_axi_bresp = '0;
    m3_axi_rvalid = 1'b0;  m3_axi_rresp = '0; m3_axi_rdata = '0;
    aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0;
    s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    forever begin
      @(negedge clk);
      aw_hs = m3_axi_awvalid && m3_axi_awready;
      w_hs  = m3_axi_wvalid && m3_axi_wready;
      b_hs  = m3_axi_bvalid && m3_axi_bready;
      ar_hs = m3_axi_arvalid && m3_axi_arready;
      r_hs  = m3_axi_rvalid && m3_axi_rready;
      if (aw_hs) s_awaddr = m3_axi_awaddr;
      if (w_hs) begin s_wdata = m3_axi_wdata; s_wstrb = m3_axi_wstrb; end
      if (ar_hs) s_araddr = m3_axi_araddr;
      @(posedge clk); #1;
      if (!rst_n) begin
        m3_axi_awready = 1'b0; m3_axi_wready = 1'b0; m3_axi_arready = 1'b0;
        m3_axi_bvalid = 1'b0; m3_axi_rvalid = 1'b0;
        aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      end else begin
        if (aw_hs) begin m3_axi_awready = 1'b0; aw_cnt = 0; aw_got = 1'b1; aw_beats++; end
        else if (m3_axi_awvalid && !m3_axi_awready) begin
          if (aw_cnt >= aw_dly) m3_axi_awready = 1'b1; else aw_cnt++;
        end
        if (w_hs) begin m3_axi_wready = 1'b0; w_cnt = 0; w_got = 1'b1; w_beats++; end
        else if (m3_axi_wvalid && !m3_axi_wready) begin
          if (w_cnt >= w_dly) m3_axi_wready = 1'b1; else w_cnt++;
        end
        if (b_hs) m3_axi_bvalid = 1'b0;
        else if (aw_got && w_got && !m3_axi_bvalid) begin
          if (b_cnt >= b_dly) begin
            for (int b = 0; b < SW; b++)
              if (s_wstrb[b]) mem[s_awaddr[7:2]][8*b +: 8] = s_wdata[8*b +: 8];
            m3_axi_bvalid = 1'b1; m3_axi_bresp = bresp_cfg;
            aw_got = 1'b0; w_got = 1'b0; b_cnt = 0;
          end else b_cnt++;
        end
        if (ar_hs) begin m3_axi_arready = 1'b0; ar_cnt = 0; ar_got = 1'b1; ar_beats++; end
        else if (m3_axi_arvalid && !m3_axi_arready) begin
          if (ar_cnt >= ar_dly) m3_axi_arready = 1'b1; else ar_cnt++;
        end
        if (r_hs) m3_axi_rvalid = 1'b0;
        else if (ar_got && !m3_axi_rvalid) begin
          if (r_cnt >= r_dly) begin
            m3_axi_rvalid = 1'b1; m3_axi_rdata = mem[s_araddr[7:2]]; m3_axi_rresp = rresp_cfg;
            ar_got = 1'b0; r_cnt = 0;
          end else r_cnt++;
        end
      end
    end
  end

  // Driver: offer one command and return just after the edge that accepted it.
  task automatic send_cmd(input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    total++;
    if (!cmd_ready) begin
      bad++;
      $display("FAIL cmd_accept: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, n);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Driver: wait for a result, accept it immediately and hand back its fields.
  task automatic get_rsp(output logic w, output logic [DW-1:0] rd, output logic [RW-1:0] rr);
    int n;
    n = 0;
    w = 1'b0; rd = '0; rr = '0;
    while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
    total++;
    if (!rsp_valid) begin
      bad++;
      $display("FAIL rsp_timeout: rsp_valid=%0b after %0d cycles, required 1", rsp_valid, n);
      return;
    end
    w = rsp_write; rd = rsp_rdata; rr = rsp_resp;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({m3_axi_awvalid, m3_axi_wvalid, m3_axi_arvalid, m3_axi_bready, m3_axi_rready, rsp_valid} !== 6'b0) begin
      bad++;
      $display("FAIL reset_valids: got %b, required 000000",
               {m3_axi_awvalid, m3_axi_wvalid, m3_axi_arvalid, m3_axi_bready, m3_axi_rready, rsp_valid});
    end
    total++;
    if ({rsp_write, rsp_rdata, rsp_resp} !== '0) begin
      bad++; $display("FAIL reset_rsp: write=%0b rdata=%h resp=%0d, required 0", rsp_write, rsp_rdata, rsp_resp);
    end
    total++;
    if ({wr_done_cnt, rd_done_cnt, err_cnt} !== '0) begin
      bad++; $display("FAIL reset_cnt: wr=%0d rd=%0d err=%0d, required 0", wr_done_cnt, rd_done_cnt, err_cnt);
    end
    total++;
    if (dbg_state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d, required 0", dbg_state); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b, required 1", cmd_ready); end
  endtask

  task automatic test_write_basic();
    logic w; logic [DW-1:0] rd; logic [RW-1:0] rr; int aw0, w0;
    aw_dly = 0; w_dly = 1; b_dly = 0; bresp_cfg = '0;
    aw0 = aw_beats; w0 = w_beats;
    send_cmd(1'b1, 8'h00, 32'h19, 4'hF);
    total++;
    if (m3_axi_awvalid !== 1'b0) begin bad++; $display("FAIL wr_latency_early: awvalid=%0b, required 0", m3_axi_awvalid); end
    @(posedge clk); #1;
    total++;
    if ({m3_axi_awvalid, m3_axi_wvalid} !== 2'b11) begin
      bad++; $display("FAIL wr_latency: aw/w valid=%b, required 11", {m3_axi_awvalid, m3_axi_wvalid});
    end
    total++;
    if ({m3_axi_awaddr, m3_axi_wdata, m3_axi_wstrb} !== {8'h00, 32'h19, 4'hF}) begin
      bad++; $display("FAIL wr_payload: addr=%h data=%h strb=%h, required 00/00000019/f", m3_axi_awaddr, m3_axi_wdata, m3_axi_wstrb);
    end
    get_rsp(w, rd, rr);
    total++;
    if ({w, rd, rr} !== {1'b1, 32'h0, 3'd0}) begin
      bad++; $display("FAIL wr_rsp: write=%0b rdata=%h resp=%0d, required 1/0/0", w, rd, rr);
    end
    total++;
    if (wr_done_cnt !== 16'd1) begin bad++; $display("FAIL wr_cnt1: got %0d, required 1", wr_done_cnt); end
    total++;
    if ((aw_beats - aw0) != 1 || (w_beats - w0) != 1) begin
      bad++; $display("FAIL wr_beats: aw=%0d w=%0d, required 1/1", aw_beats - aw0, w_beats - w0);
    end
    total++;
    if (mem[0] !== 32'h19) begin bad++; $display("FAIL wr_mem0: got %h, required 00000019", mem[0]); end
  endtask

  task automatic test_write_w_first();
    logic w; logic [DW-1:0] rd; logic [RW-1:0] rr; int split, early_b, addr_bad, n;
    aw_dly = 3; w_dly = 0; b_dly = 0; bresp_cfg = '0;
    split = 0; early_b = 0; addr_bad = 0; n = 0;
    send_cmd(1'b1, 8'h04, 32'h22, 4'hF);
    while (!m3_axi_bready && n < 40) begin
      @(posedge clk); #1; n++;
      if (m3_axi_awvalid && !m3_axi_wvalid) split++;
      if (m3_axi_bready && (m3_axi_awvalid || m3_axi_wvalid)) early_b++;
      if (m3_axi_awvalid && m3_axi_awaddr !== 8'h04) addr_bad++;
    end
    total++;
    if (split != 3) begin bad++; $display("FAIL wfirst_split: aw-held cycles=%0d, required 3", split); end
    total++;
    if (early_b != 0 || !m3_axi_bready) begin
      bad++; $display("FAIL wfirst_bready: early=%0d bready=%0b, required 0/1", early_b, m3_axi_bready);
    end
    total++;
    if (addr_bad != 0) begin bad++; $display("FAIL wfirst_addr: unstable cycles=%0d, required 0", addr_bad); end
    get_rsp(w, rd, rr);
    total++;
    if (wr_done_cnt !== 16'd2 || mem[1] !== 32'h22) begin
      bad++; $display("FAIL wfirst_done: cnt=%0d mem1=%h, required 2/00000022", wr_done_cnt, mem[1]);
    end
  endtask

  task automatic test_read_hold();
    int n;
    ar_dly = 0; r_dly = 4; rresp_cfg = '0; n = 0;
    send_cmd(1'b0, 8'h00, 32'h0, 4'h0);
    while (!rsp_valid && n < 60) begin @(posedge clk); #1; n++; end
    total++;
    if (!rsp_valid) begin bad++; $display("FAIL rd_wait: rsp_valid=%0b, required 1", rsp_valid); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({rsp_valid, rsp_write, rsp_rdata, rd_done_cnt} !== {1'b1, 1'b0, 32'h19, 16'd0}) begin
        bad++;
        $display("FAIL rd_hold%0d: valid=%0b write=%0b rdata=%h cnt=%0d, required 1/0/00000019/0",
                 i, rsp_valid, rsp_write, rsp_rdata, rd_done_cnt);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    total++;
    if ({rsp_valid, rd_done_cnt} !== {1'b0, 16'd1}) begin
      bad++; $display("FAIL rd_done: valid=%0b cnt=%0d, required 0/1", rsp_valid, rd_done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic w; logic [DW-1:0] rd; logic [RW-1:0] rr;
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    send_cmd(1'b1, 8'h08, 32'hA5A5_0001, 4'hF);
    send_cmd(1'b0, 8'h04, 32'h0, 4'h0);
    send_cmd(1'b1, 8'h0C, 32'h1234_5678, 4'h3);
    total++;
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL b2b_full: cmd_ready=%0b, required 0", cmd_ready); end
    get_rsp(w, rd, rr);
    total++;
    if ({w, rd} !== {1'b1, 32'h0}) begin bad++; $display("FAIL b2b_rsp0: write=%0b rdata=%h, required 1/0", w, rd); end
    get_rsp(w, rd, rr);
    total++;
    if ({w, rd} !== {1'b0, 32'h22}) begin bad++; $display("FAIL b2b_rsp1: write=%0b rdata=%h, required 0/22", w, rd); end
    get_rsp(w, rd, rr);
    total++;
    if ({w, rd} !== {1'b1, 32'h0}) begin bad++; $display("FAIL b2b_rsp2: write=%0b rdata=%h, required 1/0", w, rd); end
    total++;
    if ({wr_done_cnt, rd_done_cnt, err_cnt} !== {16'd4, 16'd2, 16'd0}) begin
      bad++; $display("FAIL b2b_cnt: wr=%0d rd=%0d err=%0d, required 4/2/0", wr_done_cnt, rd_done_cnt, err_cnt);
    end
    total++;
    if (mem[2] !== 32'hA5A5_0001 || mem[3] !== 32'h0000_5678) begin
      bad++; $display("FAIL b2b_mem: m2=%h m3=%h, required a5a50001/00005678", mem[2], mem[3]);
    end
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: cmd_ready=%0b, required 1", cmd_ready); end
  endtask

  task automatic test_error();
    logic w; logic [DW-1:0] rd; logic [RW-1:0] rr;
    bresp_cfg = 3'd2;
    send_cmd(1'b1, 8'h10, 32'h77, 4'hF);
    get_rsp(w, rd, rr);
    bresp_cfg = '0;
    total++;
    if (rr !== 3'd2) begin bad++; $display("FAIL err_resp: got %0d, required 2", rr); end
    total++;
    if ({err_cnt, wr_done_cnt} !== {16'd1, 16'd5}) begin
      bad++; $display("FAIL err_cnt: err=%0d wr=%0d, required 1/5", err_cnt, wr_done_cnt);
    end
  endtask

  task automatic test_reset_in_flight();
    int stray;
    aw_dly = 20; w_dly = 0; stray = 0;
    send_cmd(1'b1, 8'h20, 32'hDEAD_BEEF, 4'hF);
    @(posedge clk); #1;
    total++;
    if (m3_axi_awvalid !== 1'b1) begin bad++; $display("FAIL rif_aw: awvalid=%0b, required 1", m3_axi_awvalid); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({m3_axi_awvalid, m3_axi_wvalid, m3_axi_arvalid, m3_axi_bready, m3_axi_rready, rsp_valid} !== 6'b0) begin
      bad++;
      $display("FAIL rif_valids: got %b, required 000000",
               {m3_axi_awvalid, m3_axi_wvalid, m3_axi_arvalid, m3_axi_bready, m3_axi_rready, rsp_valid});
    end
    total++;
    if ({wr_done_cnt, rd_done_cnt, err_cnt} !== '0) begin
      bad++; $display("FAIL rif_cnt: wr=%0d rd=%0d err=%0d, required 0", wr_done_cnt, rd_done_cnt, err_cnt);
    end
    repeat (3) @(posedge clk);
    #1;
    aw_dly = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (rsp_valid || m3_axi_awvalid || m3_axi_wvalid || m3_axi_bready) stray++;
    end
    total++;
    if (stray != 0) begin bad++; $display("FAIL rif_quiet: active cycles=%0d, required 0", stray); end
    total++;
    if ({cmd_ready, wr_done_cnt} !== {1'b1, 16'd0}) begin
      bad++; $display("FAIL rif_after: ready=%0b wr=%0d, required 1/0", cmd_ready, wr_done_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_write_basic();
    test_write_w_first();
    test_read_hold();
    test_back_to_back();
    test_error();
    test_reset_in_flight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
